// File: rtl/ppu_vaddr_fetch.sv
// PPU loopy scroll registers (t/v/fine_x/w), VRAM fetch address mux and $2007 port.
// Optional PPU_PAL_READ_BYPASS_EN adds pal_din for same-cycle palette reads.
module ppu_vaddr_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_wr,
  input  logic [2:0]  reg_sel,
  input  logic [7:0]  reg_din,
  input  logic        reg_rd,
  input  logic        ppuctrl_inc,
  input  logic        render_en,
  input  logic        fetch_tile,
  input  logic        fetch_attr,
  input  logic        fetch_chr,
  input  logic [12:0] pattern_idx,
  input  logic        v_incx,
  input  logic        v_incy,
  input  logic        v_resetx,
  input  logic        v_resety,
`ifdef PPU_PAL_READ_BYPASS_EN
  input  logic [7:0]  pal_din,
`endif
  output logic [2:0]  fine_x,
  output logic [2:0]  fine_y,
  output logic [7:0]  data_o,
  output logic [1:0]  attr_o,
  output logic [7:0]  ppudata_o,
  output logic [13:0] vram_addr,
  output logic        vram_rd,
  output logic        vram_wr,
  output logic [7:0]  vram_dout,
  input  logic [7:0]  vram_din
);

  typedef enum logic [1:0] {
    S_IDLE, S_WR, S_RD, S_CAP
  } state_t;

  state_t      r_state, w_next;
  logic [14:0] r_t, r_v, w_v_nx;
  logic [2:0]  r_fx;
  logic        r_w, w_w_nx;
  logic [7:0]  r_buf, r_wd;
  logic [1:0]  r_asel;
  logic        r_attr_q;
  logic        w_wr7, w_rd7, w_acc, w_glitch;
  logic        w_step, w_buf_ld, w_cpu_rd;
  logic        w_sel0, w_sel5, w_sel6;
  logic        w_t2v, w_pal;
  logic [14:0] w_inc;
  logic [7:0]  w_ash;

  function automatic logic [14:0] inc_x(input logic [14:0] v);
    logic [14:0] r;
    r = v;
    if (v[4:0] == 5'd31) begin
      r[4:0] = 5'd0;
      r[10]  = ~v[10];
    end else begin
      r[4:0] = v[4:0] + 5'd1;
    end
    return r;
  endfunction

  function automatic logic [14:0] inc_y(input logic [14:0] v);
    logic [14:0] r;
    r = v;
    if (v[14:12] != 3'd7) begin
      r[14:12] = v[14:12] + 3'd1;
    end else begin
      r[14:12] = 3'd0;
      if (v[9:5] == 5'd29) begin
        r[9:5] = 5'd0;
        r[11]  = ~v[11];
      end else if (v[9:5] == 5'd31) begin
        r[9:5] = 5'd0;
      end else begin
        r[9:5] = v[9:5] + 5'd1;
      end
    end
    return r;
  endfunction

  assign w_sel0   = (reg_sel == 3'd0);
  assign w_sel5   = (reg_sel == 3'd5);
  assign w_sel6   = (reg_sel == 3'd6);
  assign w_wr7    = reg_wr && (reg_sel == 3'd7);
  assign w_rd7    = reg_rd && (reg_sel == 3'd7);
  assign w_acc    = w_wr7 || w_rd7;
  assign w_glitch = (r_state == S_IDLE) && render_en && w_acc;
  assign w_t2v    = reg_wr && w_sel6 && r_w;
  assign w_inc    = ppuctrl_inc ? 15'd32 : 15'd1;
  assign w_pal    = (r_v[13:8] == 6'h3F);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    vram_wr   = 1'b0;
    vram_dout = 8'h00;
    w_cpu_rd  = 1'b0;
    w_step    = 1'b0;
    w_buf_ld  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!render_en && w_wr7)      w_next = S_WR;
        else if (!render_en && w_rd7) w_next = S_RD;
      end
      S_WR: begin
        vram_wr   = 1'b1;
        vram_dout = r_wd;
        w_step    = 1'b1;
        w_next    = S_IDLE;
      end
      S_RD: begin
        w_cpu_rd = 1'b1;
        w_next   = S_CAP;
      end
      S_CAP: begin
        w_buf_ld = 1'b1;
        w_step   = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Second $2006 write beats the renderer strobes, which beat increments.
  always_comb begin
    w_v_nx = r_v;
    if (w_t2v) begin
      w_v_nx = {r_t[14:8], reg_din};
    end else if (v_resetx || v_resety) begin
      if (v_resetx) begin
        w_v_nx[10]  = r_t[10];
        w_v_nx[4:0] = r_t[4:0];
      end
      if (v_resety) begin
        w_v_nx[14:11] = r_t[14:11];
        w_v_nx[9:5]   = r_t[9:5];
      end
    end else if (v_incx || v_incy || w_glitch) begin
      if (v_incx || w_glitch) w_v_nx = inc_x(w_v_nx);
      if (v_incy || w_glitch) w_v_nx = inc_y(w_v_nx);
    end else if (w_step) begin
      w_v_nx = r_v + w_inc;
    end
  end

  always_comb begin
    w_w_nx = r_w;
    if (reg_wr && (w_sel5 || w_sel6)) w_w_nx = ~r_w;
    if (reg_rd && (reg_sel == 3'd2))  w_w_nx = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t  <= '0;
      r_v  <= '0;
      r_fx <= '0;
      r_w  <= 1'b0;
    end else begin
      r_v <= w_v_nx;
      r_w <= w_w_nx;
      if (reg_wr) begin
        unique case (1'b1)
          w_sel0: r_t[11:10] <= reg_din[1:0];
          w_sel5: begin
            if (!r_w) begin
              r_t[4:0] <= reg_din[7:3];
              r_fx     <= reg_din[2:0];
            end else begin
              r_t[14:12] <= reg_din[2:0];
              r_t[9:5]   <= reg_din[7:3];
            end
          end
          w_sel6: begin
            if (!r_w) r_t[14:8] <= {1'b0, reg_din[5:0]};
            else      r_t[7:0]  <= reg_din;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf    <= '0;
      r_wd     <= '0;
      r_asel   <= '0;
      r_attr_q <= 1'b0;
    end else begin
      r_attr_q <= fetch_attr;
      if (fetch_attr && !r_attr_q) r_asel <= {r_v[6], r_v[1]};
      if (w_buf_ld) r_buf <= vram_din;
      if (r_state == S_IDLE && w_wr7) r_wd <= reg_din;
    end
  end

  always_comb begin
    vram_addr = r_v[13:0];
    if (fetch_chr)
      vram_addr = {1'b0, pattern_idx};
    else if (fetch_attr)
      vram_addr = {2'b10, r_v[11:10], 4'hF, r_v[9:7], r_v[4:2]};
    else if (fetch_tile)
      vram_addr = {2'b10, r_v[11:0]};
`ifdef PPU_PAL_READ_BYPASS_EN
    else if (w_cpu_rd && w_pal)
      vram_addr = r_v[13:0] & 14'h2FFF;
`endif
  end

  always_comb begin
    ppudata_o = r_buf;
`ifdef PPU_PAL_READ_BYPASS_EN
    if (w_rd7 && w_pal) ppudata_o = pal_din;
`endif
  end

  assign w_ash   = vram_din >> {r_asel, 1'b0};
  assign attr_o  = w_ash[1:0];
  assign vram_rd = fetch_tile || fetch_attr || fetch_chr || w_cpu_rd;
  assign data_o  = vram_din;
  assign fine_x  = r_fx;
  assign fine_y  = r_v[14:12];

endmodule
